// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-requester byte-bus memory arbiter.
package mem_pkg;

  // IDLE      | bus idle, arbitrate and grant one requester
  // READ      | issue read byte addresses, capture the previous byte
  // READ_TAIL | capture the final byte, extend, raise resp_valid
  // WRITE     | drive one byte per cycle, stall on a full UART buffer
  typedef enum logic [1:0] {IDLE, READ, READ_TAIL, WRITE} state_e;

  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int         IO_HI     = 17;
  localparam int         IO_LO     = 16;

  // A length field holds byte count minus 1, so it needs clog2(max bytes) bits.
  function automatic int len_width(input int data_bytes);
    return (data_bytes > 1) ? $clog2(data_bytes) : 1;
  endfunction

  function automatic int ptr_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// One-hot grant from the request vector. MEM_ARBITER_RR_EN selects round-robin
// from the pointer; otherwise fixed priority with the lowest index winning.
module mem_arb_grant import mem_pkg::*; #(
  parameter int N_CH = 2
`ifdef MEM_ARBITER_RR_EN
  ,
  parameter int PTR_W = ptr_width(N_CH)
`endif
) (
`ifdef MEM_ARBITER_RR_EN
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] ptr_nxt_o,
`endif
  input  logic [N_CH-1:0]  req_valid_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic             gnt_any_o
);

  logic [N_CH-1:0] pick;

`ifdef MEM_ARBITER_RR_EN
  logic [N_CH-1:0] at_or_after;

  // Prefer requesters at or above the pointer; fall back to the full vector to wrap.
  always_comb begin
    at_or_after = '0;
    for (int i = 0; i < N_CH; i++) at_or_after[i] = (i >= int'(ptr_i));
    pick = ((req_valid_i & at_or_after) != '0) ? (req_valid_i & at_or_after) : req_valid_i;
  end
`else
  assign pick = req_valid_i;
`endif

  always_comb begin
    gnt_o = '0;
`ifdef MEM_ARBITER_RR_EN
    ptr_nxt_o = ptr_i;
`endif
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
`ifdef MEM_ARBITER_RR_EN
        ptr_nxt_o = (i == N_CH - 1) ? '0 : PTR_W'(i + 1);
`endif
      end
    end
  end

  assign gnt_any_o = |req_valid_i;

endmodule

// File: rtl/mem_arbiter.sv
// N_CH-requester arbiter onto the 8-bit memory bus with read assembly/extension
// and UART write stalls. MEM_ARBITER_RR_EN enables round-robin arbitration.
module mem_arbiter import mem_pkg::*; #(
  parameter int N_CH       = 2,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = len_width(DATA_BYTES)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic [N_CH-1:0]              req_valid,
  input  logic [N_CH-1:0]              req_we,
  input  logic [N_CH-1:0]              req_signed,
  input  logic [N_CH*LEN_W-1:0]        req_len,
  input  logic [N_CH*ADDR_W-1:0]       req_addr,
  input  logic [N_CH*DATA_BYTES*8-1:0] req_wdata,
  output logic [N_CH-1:0]              req_ack,
  output logic [N_CH-1:0]              resp_valid,
  output logic [DATA_BYTES*8-1:0]      resp_data,
  input  logic [7:0]                   mem_din,
  output logic [7:0]                   mem_dout,
  output logic [ADDR_W-1:0]            mem_a,
  output logic                         mem_wr,
  input  logic                         io_buffer_full
);

  localparam int DW = DATA_BYTES * 8;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sgn_q, sgn_d;
  logic [DW-1:0]     data_q, data_d;
  logic [N_CH-1:0]   own_q, own_d, resp_q, resp_d;

  logic [N_CH-1:0]   gnt;
  logic              gnt_any, grant_ok, io_stall;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] sel_addr, cur_addr;
  logic [DW-1:0]     sel_wdata;
  logic              sel_we, sel_sgn;
  logic [7:0]        cur_wbyte;

`ifdef MEM_ARBITER_RR_EN
  localparam int PTR_W = ptr_width(N_CH);
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;

  mem_arb_grant #(.N_CH(N_CH), .PTR_W(PTR_W)) u_grant (
    .ptr_i       (ptr_q),
    .ptr_nxt_o   (ptr_nxt),
    .req_valid_i (req_valid),
    .gnt_o       (gnt),
    .gnt_any_o   (gnt_any)
  );
`else
  mem_arb_grant #(.N_CH(N_CH)) u_grant (
    .req_valid_i (req_valid),
    .gnt_o       (gnt),
    .gnt_any_o   (gnt_any)
  );
`endif

  always_comb begin
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_sgn   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_len   = req_len[i*LEN_W +: LEN_W];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_we    = req_we[i];
        sel_sgn   = req_signed[i];
      end
    end
  end

  assign cur_addr = addr_q + ADDR_W'(cnt_q);
  assign grant_ok = (state_q == IDLE) && gnt_any && !flush;
  assign io_stall = (state_q == WRITE) && (cur_addr[IO_HI:IO_LO] == IO_REGION) && io_buffer_full;

  always_comb begin
    cur_wbyte = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (int'(cnt_q) == i) cur_wbyte = data_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    sgn_d   = sgn_q;
    data_d  = data_q;
    own_d   = own_q;
    resp_d  = '0;
`ifdef MEM_ARBITER_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = sel_we ? WRITE : READ;
          cnt_d   = '0;
          len_d   = sel_len;
          addr_d  = sel_addr;
          sgn_d   = sel_sgn;
          data_d  = sel_we ? sel_wdata : '0;
          own_d   = gnt;
`ifdef MEM_ARBITER_RR_EN
          ptr_d   = ptr_nxt;
`endif
        end
      end
      READ: begin
        // mem_din carries the byte addressed one cycle earlier.
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (int'(cnt_q) == i + 1) data_d[i*8 +: 8] = mem_din;
        end
        if (flush)                 state_d = IDLE;
        else if (cnt_q == len_q)   state_d = READ_TAIL;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      READ_TAIL: begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (int'(len_q) == i)     data_d[i*8 +: 8] = mem_din;
          else if (i > int'(len_q)) data_d[i*8 +: 8] = {8{sgn_q & mem_din[7]}};
        end
        state_d = IDLE;
        if (!flush) resp_d = own_q;
      end
      WRITE: begin
        if (!io_stall) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
            resp_d  = own_q;
            data_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      sgn_q   <= 1'b0;
      data_q  <= '0;
      own_q   <= '0;
      resp_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
      ptr_q   <= '0;
`endif
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      sgn_q   <= sgn_d;
      data_q  <= data_d;
      own_q   <= own_d;
      resp_q  <= resp_d;
`ifdef MEM_ARBITER_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    req_ack    = (grant_ok && rdy_in && rst_in) ? gnt : '0;
    resp_valid = resp_q;
    resp_data  = data_q;
    mem_a      = (state_q == READ || state_q == WRITE) ? cur_addr : '0;
    mem_wr     = (state_q == WRITE) && !io_stall && rdy_in;
    mem_dout   = (state_q == WRITE) ? cur_wbyte : '0;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the CPU's single-requester byte-bus memory controller.
- Arbitrates N_CH requesters (I-cache, LSB, future D-cache/prefetch) onto the 8-bit external memory bus.
- Serialises multi-byte reads and writes, assembles and sign-extends read data, and stalls I/O writes while the UART buffer is full.
- Sits between the requesting units and the cpu top-level mem_* pins.

Parameters:
- N_CH, 2, number of requester channels (1..8); channel 0 is the highest-priority index.
- DATA_BYTES, 4, maximum transfer size in bytes (power of two, 1..8).
- ADDR_W, 32, address width.
- LEN_W, $clog2(DATA_BYTES) (min 1), width of each length field; a length field holds the byte count minus 1.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low freezes the block
- flush  in  1  misprediction flush; aborts reads
- req_valid  in  N_CH  per-channel request
- req_we  in  N_CH  1 = write
- req_signed  in  N_CH  1 = sign-extend read result
- req_len  in  N_CH*LEN_W  per-channel byte count minus 1
- req_addr  in  N_CH*ADDR_W  per-channel start address
- req_wdata  in  N_CH*DATA_BYTES*8  write data, little-endian
- req_ack  out  N_CH  one-hot, 1-cycle pulse: request accepted
- resp_valid  out  N_CH  one-hot, 1-cycle pulse: transfer done
- resp_data  out  DATA_BYTES*8  read result; valid only with resp_valid
- mem_din  in  8  memory read byte
- mem_dout  out  8  memory write byte
- mem_a  out  ADDR_W  memory byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART buffer full

Behaviour:
Reset (rst_in low at a clock edge):
- State goes to IDLE.
- All outputs 0, data register 0, round-robin pointer 0.
- Reset mid-transfer abandons the transfer silently.

rdy_in low:
- No state, counter or pointer update; mem_wr forced to 0; mem_a held.
- On resume, the pending byte address is re-presented, so a read byte is re-fetched.
- Duplicate reads of I/O address 0x30000 are not protected against; the bench keeps rdy_in high around I/O reads.

State machine:
- States: IDLE, READ, READ_TAIL, WRITE.
- IDLE: if any req_valid and flush is low, grant one channel g. req_ack[g] pulses this cycle T; addr, len, we, signed and wdata are latched. Go to READ or WRITE.
- READ: mem_a = addr+i in cycle T+1+i, for i = 0..len. Byte i is sampled from mem_din in cycle T+2+i into byte lane i. After issuing byte len, go to READ_TAIL.
- READ_TAIL: capture the last byte, then go to IDLE. resp_valid[g] and resp_data are registered and asserted in cycle T+len+3, the first IDLE cycle.
- Read extension: lanes above len are sign-extended from bit 7 of lane len when signed=1, otherwise zero-filled.
- Read occupancy is len+3 cycles; a new grant is possible in the resp_valid cycle.
- WRITE: mem_a = addr+i, mem_dout = wdata lane i, mem_wr = 1 in cycle T+1+i. resp_valid[g] pulses in the cycle after the last byte. No read data is returned.
- I/O stall: if addr[17:16] == 2'b11, we = 1 and io_buffer_full = 1, the current byte is held with mem_wr = 0 and retried every cycle until the buffer is not full.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Bus idle (IDLE, READ_TAIL): mem_wr = 0, mem_a = 0, mem_dout = 0.

flush:
- In IDLE: no grant that cycle.
- In READ or READ_TAIL: go to IDLE next cycle with no resp_valid.
- In WRITE: ignored; stores are committed and always complete.
- A flush coinciding with the READ_TAIL capture also suppresses resp_valid.

Requesters:
- Must hold request fields stable from req_valid until req_ack.
- A new request may be presented the cycle after req_ack.
- len > DATA_BYTES-1 is impossible by width.

Optional Feature:
- MEM_ARBITER_RR_EN defined: round-robin arbitration. The grant goes to the first valid channel at or after the pointer; the pointer then becomes g+1 mod N_CH.
- Undefined: fixed priority, lowest index wins; no pointer register exists.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, READ, READ_TAIL, WRITE}
  - IO_REGION constant 2'b11 and the address bit range [17:16]
  - len encoding helpers
- One natural sub-module, mem_arb_grant: combinational one-hot grant from req_valid plus the RR pointer, holding the macro-dependent logic.

Test Plan:
- Single read, ch1, addr 0x100, len 3, signed 0, memory bytes 0x78,0x56,0x34,0x12 → req_ack[1] at T; mem_a 0x100..0x103 at T+1..T+4; resp_valid[1] at T+6 with resp_data 0x12345678.
- Signed byte read, byte 0x80 → resp_data 0xFFFFFF80. Same with signed 0 → 0x00000080.
- Simultaneous req_valid on ch0 and ch1, repeated → with RR_EN, grants alternate 0,1,0,1. Without RR_EN, ch0 always wins and ch1 starves.
- Write 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then 1 with mem_dout 0x41; resp_valid the following cycle.
- flush asserted at T+2 of a 4-byte read → no resp_valid; IDLE at T+3; a pending ch0 request is acked at T+3. A flush during a write does not truncate it: 4 mem_wr pulses occur.
- rst_in low mid-write → all outputs 0 next cycle; no further mem_wr.
